// File: rtl/stream_mux_if.sv
`default_nettype none
//==============================================================================
// Module      : stream_mux_if
// Description : Handshake bundle for stream_mux. Carries the per-channel
//               input streams, the select/mode controls and the single
//               registered output stream.
//               master = upstream/downstream environment, slave = the mux.
// Revision    : 1.0 - initial release
//==============================================================================
interface stream_mux_if #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
);
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [SEL_W-1:0]          sel;
    logic                      mode;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_chan;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        output in_data, in_valid, sel, mode, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );

    modport slave (
        input  in_data, in_valid, sel, mode, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/stream_mux.sv
`default_nettype none
//==============================================================================
// Module      : stream_mux
// Description : N-channel valid/ready stream multiplexer with a single
//               registered output slot. Channel chosen by explicit select,
//               or by round-robin when built with STREAM_MUX_RR_EN.
//               Config macro: STREAM_MUX_RR_EN (undefined -> mode ignored,
//               explicit select only, no round-robin pointer).
// Revision    : 1.0 - initial release
//==============================================================================
module stream_mux #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    stream_mux_if.slave bus
);

    localparam logic [SEL_W:0]   c_chans = (SEL_W+1)'(CHANNELS);

    logic [WIDTH-1:0]    r_out_data;
    logic [SEL_W-1:0]    r_out_chan;
    logic                r_out_valid;

    logic                w_can_load;
    logic [SEL_W-1:0]    w_cand;
    logic                w_cand_ok;
    logic [CHANNELS-1:0] w_ready;
    logic [WIDTH-1:0]    w_data;
    logic                w_xfer;

    // Slot accepts a new word when empty or when its word leaves this cycle
    assign w_can_load = !r_out_valid || bus.out_ready;

`ifdef STREAM_MUX_RR_EN
    localparam logic [SEL_W-1:0] c_last  = SEL_W'(CHANNELS - 1);

    logic [SEL_W-1:0]    r_rr_ptr;
    logic [CHANNELS-1:0] w_rot;
    logic [SEL_W-1:0]    w_off;
    logic                w_rr_found;
    logic [SEL_W:0]      w_sum;
    logic [SEL_W-1:0]    w_rr_cand;
    logic [SEL_W-1:0]    w_rr_next;

    // Rotate valids so bit 0 is the channel at rr_ptr; the doubled copy gives the wrap
    assign w_rot = CHANNELS'({bus.in_valid, bus.in_valid} >> r_rr_ptr);

    // Lowest set bit of the rotated vector is the first requester at/after rr_ptr
    always_comb begin
        w_off      = '0;
        w_rr_found = 1'b0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off      = SEL_W'(k);
                w_rr_found = 1'b1;
            end
        end
    end

    assign w_sum     = {1'b0, r_rr_ptr} + {1'b0, w_off};
    assign w_rr_cand = (w_sum >= c_chans) ? SEL_W'(w_sum - c_chans) : w_sum[SEL_W-1:0];
    assign w_rr_next = (w_cand == c_last) ? '0 : w_cand + 1'b1;

    // Pointer moves past the granted channel only on a round-robin transfer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_xfer && bus.mode) begin
            r_rr_ptr <= w_rr_next;
        end
    end
`else
    logic w_unused_mode;
    assign w_unused_mode = bus.mode;
`endif

    // Pick the candidate channel; out-of-range select yields no candidate
    always_comb begin
        w_cand    = bus.sel;
        w_cand_ok = ({1'b0, bus.sel} < c_chans);
`ifdef STREAM_MUX_RR_EN
        if (bus.mode) begin
            w_cand    = w_rr_cand;
            w_cand_ok = w_rr_found;
        end
`endif
    end

    // One-hot ready for the candidate and its data, gated off during reset
    always_comb begin
        w_ready = '0;
        w_data  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (w_cand == SEL_W'(c)) begin
                w_data     = bus.in_data[c*WIDTH +: WIDTH];
                w_ready[c] = rst_n && w_cand_ok && w_can_load;
            end
        end
    end

    assign w_xfer       = |(w_ready & bus.in_valid);
    assign bus.in_ready = w_ready;

    // Output slot: load on transfer, empty on drain without refill, hold on stall
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_data;
            r_out_chan  <= w_cand;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.out_data  = r_out_data;
    assign bus.out_chan  = r_out_chan;
    assign bus.out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: doc/stream_mux.md
STREAM_MUX -- requirements
Module: stream_mux

Interface
REQ-001 Parameter WIDTH, default 32, data width per channel in bits.
REQ-002 Parameter CHANNELS, default 4, number of input channels (2..16).
REQ-003 Parameter SEL_W, default 2, select/channel-id width, equal to ceil(log2(CHANNELS)).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  CHANNELS  per-channel valid.
REQ-008 in_ready  output  CHANNELS  per-channel ready; at most one bit high per cycle.
REQ-009 sel  input  SEL_W  explicit channel select, used when mode=0.
REQ-010 mode  input  1  0 = explicit select, 1 = round-robin.
REQ-011 out_data  output  WIDTH  registered selected data.
REQ-012 out_chan  output  SEL_W  channel index of out_data.
REQ-013 out_valid  output  1  out_data/out_chan valid.
REQ-014 out_ready  input  1  downstream ready.

Function
REQ-015 Output stage SHALL be a single register slot; it can load when (!out_valid) or (out_valid && out_ready).
REQ-016 Candidate channel: mode=0 -> sel; mode=1 -> first channel with in_valid set, searching upward from rr_ptr with wrap CHANNELS-1 -> 0.
REQ-017 in_ready[c] SHALL be high only for the candidate c, only when the slot can load, combinationally, in the same cycle.
REQ-018 Transfer on in_valid[c] && in_ready[c]; at that edge out_data <= channel c data, out_chan <= c, out_valid <= 1; latency 1 cycle.
REQ-019 If out_valid && out_ready and no transfer occurs, out_valid SHALL clear at the edge.
REQ-020 Simultaneous drain and transfer in the same cycle SHALL sustain 1 word/cycle with no bubble.
REQ-021 While out_valid && !out_ready, out_data and out_chan SHALL hold stable regardless of sel, mode or inputs.
REQ-022 sel >= CHANNELS in mode 0 SHALL grant nothing (all in_ready low); no X propagation.
REQ-023 Mode 1 with no in_valid set SHALL grant nothing; rr_ptr unchanged.
REQ-024 rr_ptr SHALL advance to (granted channel + 1) mod CHANNELS only on a mode-1 transfer; mode-0 transfers leave it unchanged.
REQ-025 mode or sel changes take effect in the same cycle; no transfer is lost or duplicated.

Reset
REQ-026 rst_n=0 at a rising edge SHALL set out_valid=0, out_data=0, out_chan=0, rr_ptr=0.
REQ-027 in_ready SHALL be all-zero while rst_n=0.
REQ-028 Reset mid-operation SHALL discard any held word; it is not delivered after reset release.

Configuration
REQ-029 Macro STREAM_MUX_RR_EN: defined -> round-robin logic and rr_ptr present, mode behaves per REQ-016.
REQ-030 STREAM_MUX_RR_EN undefined -> mode input ignored, explicit select only, rr_ptr absent; all other behaviour identical.

Verification
REQ-031 Mode 0, sel=1, in_valid=4'b0010, ch1=0x00000002, out_ready=1 -> in_ready=4'b0010; next cycle out_data=0x2, out_chan=1, out_valid=1.
REQ-032 Mode 0 word held, out_ready=0 for 3 cycles, sel changed to 0 -> out_data/out_chan unchanged, in_ready=0; release out_ready -> ch0 loaded next cycle.
REQ-033 Mode 1, in_valid=4'b1111 constant, out_ready=1 -> out_chan sequence 0,1,2,3,0 on consecutive cycles, no bubbles.
REQ-034 Mode 1, in_valid=4'b1001, rr_ptr=1 -> grant ch3, then ch0, then ch3 (wrap).
REQ-035 Mode 0, sel=3'd5 with CHANNELS=4, SEL_W=3 -> in_ready all-zero, out_valid stays 0.
REQ-036 rst_n=0 for one edge while out_valid=1 holding 0x3 -> out_valid=0, out_data=0 next cycle; held word never appears.
